// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: ready/valid byte in, LSB-first serial frame out.
// Line idles high and is driven straight from a flop.
module uart_transmitter #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out
);

  localparam int SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE;
  localparam int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] TIMER_MAX =
    CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);

  if (SYMBOL_EDGE_TIME < 2) begin : g_bad_rate
    $error("uart_transmitter: SYMBOL_EDGE_TIME must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                         state_q, state_d;
  logic [CLOCK_COUNTER_WIDTH-1:0] timer_q, timer_d;
  logic [2:0]                     idx_q, idx_d;
  logic [7:0]                     shift_q, shift_d;
  logic                           tx_q, tx_d;
  logic                           wrap;
  logic [2:0]                     idx_nxt;

  assign wrap          = (timer_q == TIMER_MAX);
  assign idx_nxt       = idx_q + 3'd1;
  assign data_in_ready = (state_q == IDLE);
  assign serial_out    = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Line level is only updated on state entry or timer wrap.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        tx_d    = 1'b1;
        if (data_in_valid) begin
          state_d = START;
          shift_d = data_in;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (wrap) begin
          state_d = DATA;
          timer_d = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (wrap) begin
          timer_d = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_nxt;
            tx_d  = shift_q[idx_nxt];
          end
        end
      end
      STOP: begin
        if (wrap) begin
          state_d = IDLE;
          timer_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: 10-cycle/bit instance plus
// a default-parameter instance, frames decoded by mid-bit sampling.
module tb_uart_transmitter;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       valid_t, valid_d;
  logic       rdy_t, rdy_d;
  logic       so_t, so_d;

  int n_checks;
  int n_errors;

  uart_transmitter #(
    .CLOCK_FREQ(1000),
    .BAUD_RATE (100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_in_valid(valid_t),
    .data_in_ready(rdy_t),
    .serial_out   (so_t)
  );

  uart_transmitter dut_def (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_in_valid(valid_d),
    .data_in_ready(rdy_d),
    .serial_out   (so_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic line(input bit d);
    return d ? so_d : so_t;
  endfunction

  function automatic logic rdy(input bit d);
    return d ? rdy_d : rdy_t;
  endfunction

  // Handshake at the next edge; returns at position 0 of the frame.
  task automatic send(input bit d, input logic [7:0] b);
    data_in = b;
    if (d) valid_d = 1'b1;
    else valid_t = 1'b1;
    step();
    valid_t = 1'b0;
    valid_d = 1'b0;
  endtask

  task automatic capture(input bit d, input int set,
                         output logic [9:0] bits, output int low,
                         output int start_len, output int stop_at);
    bit run;
    bits      = '0;
    low       = 0;
    start_len = 0;
    stop_at   = -1;
    run       = 1'b1;
    for (int p = 0; p < 10 * set; p++) begin
      if (p % set == set / 2) bits[p/set] = line(d);
      if (!rdy(d)) low++;
      if (run && !line(d)) start_len++;
      else run = 1'b0;
      if (stop_at < 0 && p >= 9 * set && line(d)) stop_at = p;
      step();
    end
  endtask

  logic [9:0] bits;
  int         low, slen, sat;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    data_in  = 8'h00;
    valid_t  = 1'b1;
    valid_d  = 1'b0;

    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_line", 32'(so_t), 32'd1);
      check("rst_rdy", 32'(rdy_t), 32'd1);
    end
    valid_t = 1'b0;
    rst     = 1'b0;
    step();
    check("post_rst_line", 32'(so_t), 32'd1);
    check("post_rst_rdy", 32'(rdy_t), 32'd1);
    check("def_rst_line", 32'(so_d), 32'd1);

    send(1'b0, 8'hA5);
    capture(1'b0, 10, bits, low, slen, sat);
    check("a5_bits", 32'(bits), 32'({1'b1, 8'hA5, 1'b0}));
    check("a5_rdy_low", 32'(low), 32'd100);
    check("a5_rdy_after", 32'(rdy_t), 32'd1);
    check("a5_line_after", 32'(so_t), 32'd1);

    send(1'b1, 8'h55);
    capture(1'b1, 434, bits, low, slen, sat);
    check("def_start_len", 32'(slen), 32'd434);
    check("def_frame_len", 32'(low), 32'd4340);
    check("def_byte", 32'(bits[8:1]), 32'h55);
    check("def_stop", 32'(bits[9]), 32'd1);
    check("def_rdy_after", 32'(rdy_d), 32'd1);

    data_in = 8'h00;
    valid_t = 1'b1;
    step();
    data_in = 8'hFF;
    capture(1'b0, 10, bits, low, slen, sat);
    check("b2b_byte0", 32'(bits[8:1]), 32'h00);
    check("b2b_stop_at", 32'(sat), 32'd90);
    check("b2b_idle_line", 32'(so_t), 32'd1);
    check("b2b_idle_rdy", 32'(rdy_t), 32'd1);
    step();
    valid_t = 1'b0;
    check("b2b_gap", 32'(so_t == 1'b0 ? 101 - sat : 0), 32'd11);
    check("b2b_rdy_low", 32'(rdy_t), 32'd0);
    capture(1'b0, 10, bits, low, slen, sat);
    check("b2b_byte1", 32'(bits[8:1]), 32'hFF);
    check("b2b_start1", 32'(slen), 32'd10);

    send(1'b0, 8'h3C);
    data_in = 8'hC3;
    capture(1'b0, 10, bits, low, slen, sat);
    check("stable_byte", 32'(bits[8:1]), 32'h3C);

    send(1'b0, 8'hF0);
    repeat (35) step();
    check("mid_busy", 32'(rdy_t), 32'd0);
    rst = 1'b1;
    step();
    check("mid_rst_line", 32'(so_t), 32'd1);
    check("mid_rst_rdy", 32'(rdy_t), 32'd1);
    rst = 1'b0;
    step();
    check("mid_idle_line", 32'(so_t), 32'd1);
    send(1'b0, 8'h81);
    capture(1'b0, 10, bits, low, slen, sat);
    check("after_rst_bits", 32'(bits), 32'({1'b1, 8'h81, 1'b0}));
    check("after_rst_low", 32'(low), 32'd100);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
